// File: rtl/sprite_renderer_if.sv
// Video bus between the timing generator and the sprite renderer: pixel
// coordinates and frame pulse in, RGB565 pixel with its data-enable out.
interface sprite_renderer_if;
    logic        de_in;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic        frame_start;
    logic        LCD_DE;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;

    modport master (
        output de_in, x_in, y_in, frame_start,
        input  LCD_DE, LCD_R, LCD_G, LCD_B
    );

    modport slave (
        input  de_in, x_in, y_in, frame_start,
        output LCD_DE, LCD_R, LCD_G, LCD_B
    );
endinterface

// File: rtl/sprite_renderer.sv
// Bouncing 16x16 sprite overlay with a two-stage pixel pipeline.
// Optional SPRITE_COLOR_CYCLE_EN: sprite colour steps through 8 colours on each bounce.
//
//   state | meaning
//   RD    | moving right, moving down
//   RU    | moving right, moving up
//   LD    | moving left,  moving down
//   LU    | moving left,  moving up
module sprite_renderer #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int STEP     = 1
) (
    input  logic            PixelClk,
    input  logic            nRST,
    sprite_renderer_if.slave vid
);

    localparam logic [15:0] X_MAX  = 16'(H_ACTIVE - 16);
    localparam logic [15:0] Y_MAX  = 16'(V_ACTIVE - 16);
    localparam logic [15:0] STEP_W = 16'(STEP);

    // Encoding is {dir_x, dir_y} so the flags fall straight out of the state.
    typedef enum logic [1:0] {
        RD = 2'b00,
        RU = 2'b01,
        LD = 2'b10,
        LU = 2'b11
    } motion_t;

    motion_t     state_q, state_d;
    logic [15:0] spx, spy;
    logic [15:0] spx_d, spy_d;
    logic        dir_x, dir_y;
    logic        dir_x_d, dir_y_d;

    assign dir_x = state_q[1];
    assign dir_y = state_q[0];

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q <= RD;
            spx     <= '0;
            spy     <= '0;
        end else begin
            state_q <= state_d;
            spx     <= spx_d;
            spy     <= spy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        spx_d   = spx;
        spy_d   = spy;
        dir_x_d = dir_x;
        dir_y_d = dir_y;
        if (vid.frame_start) begin
            if (!dir_x) begin
                if (spx + STEP_W >= X_MAX) begin
                    spx_d   = X_MAX;
                    dir_x_d = 1'b1;
                end else begin
                    spx_d = spx + STEP_W;
                end
            end else begin
                if (spx <= STEP_W) begin
                    spx_d   = '0;
                    dir_x_d = 1'b0;
                end else begin
                    spx_d = spx - STEP_W;
                end
            end

            if (!dir_y) begin
                if (spy + STEP_W >= Y_MAX) begin
                    spy_d   = Y_MAX;
                    dir_y_d = 1'b1;
                end else begin
                    spy_d = spy + STEP_W;
                end
            end else begin
                if (spy <= STEP_W) begin
                    spy_d   = '0;
                    dir_y_d = 1'b0;
                end else begin
                    spy_d = spy - STEP_W;
                end
            end

            state_d = motion_t'({dir_x_d, dir_y_d});
        end
    end

    logic [4:0] spr_r;
    logic [5:0] spr_g;
    logic [4:0] spr_b;

`ifdef SPRITE_COLOR_CYCLE_EN
    // Every clamp flips a direction flag, so any state change is one bounce,
    // including a corner hit where both flags flip together.
    logic       bounce;
    logic [2:0] col_idx;

    assign bounce = (state_d != state_q);

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            col_idx <= '0;
        end else if (bounce) begin
            col_idx <= col_idx + 3'd1;
        end
    end

    always_comb begin
        spr_r = col_idx[0] ? 5'd31 : 5'd0;
        spr_g = col_idx[1] ? 6'd63 : 6'd0;
        spr_b = col_idx[2] ? 5'd31 : 5'd0;
        if (col_idx == 3'd0) begin
            spr_r = 5'd31;
            spr_g = 6'd63;
            spr_b = 5'd31;
        end
    end
`else
    assign spr_r = 5'd0;
    assign spr_g = 6'd63;
    assign spr_b = 5'd0;
`endif

    function automatic logic [15:0] rom_row(input logic [3:0] r);
        logic [15:0] bits;
        case (r)
            4'd0:    bits = 16'hFFFF;
            4'd1:    bits = 16'h8001;
            4'd2:    bits = 16'hBFFD;
            4'd3:    bits = 16'hA005;
            4'd4:    bits = 16'hAFF5;
            4'd5:    bits = 16'hA815;
            4'd6:    bits = 16'hABD5;
            4'd7:    bits = 16'hAA55;
            4'd8:    bits = 16'hAA55;
            4'd9:    bits = 16'hABD5;
            4'd10:   bits = 16'hA815;
            4'd11:   bits = 16'hAFF5;
            4'd12:   bits = 16'hA005;
            4'd13:   bits = 16'hBFFD;
            4'd14:   bits = 16'h8001;
            default: bits = 16'hFFFF;
        endcase
        return bits;
    endfunction

    // Unsigned wrap makes pixels left of / above the sprite land far above 15.
    logic [15:0] dx, dy;
    assign dx = vid.x_in - spx;
    assign dy = vid.y_in - spy;

    logic       de_s1;
    logic       hit_s1;
    logic [3:0] row_s1;
    logic [3:0] col_s1;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_s1  <= 1'b0;
            hit_s1 <= 1'b0;
            row_s1 <= '0;
            col_s1 <= '0;
        end else begin
            de_s1  <= vid.de_in;
            hit_s1 <= (dx < 16'd16) && (dy < 16'd16);
            row_s1 <= dy[3:0];
            col_s1 <= dx[3:0];
        end
    end

    logic [15:0] rom_bits;
    logic        lit;
    assign rom_bits = rom_row(row_s1);
    assign lit      = rom_bits[4'd15 - col_s1];

    logic       de_s2;
    logic [4:0] r_s2;
    logic [5:0] g_s2;
    logic [4:0] b_s2;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_s2 <= 1'b0;
            r_s2  <= '0;
            g_s2  <= '0;
            b_s2  <= '0;
        end else begin
            de_s2 <= de_s1;
            if (de_s1 && hit_s1 && lit) begin
                r_s2 <= spr_r;
                g_s2 <= spr_g;
                b_s2 <= spr_b;
            end else begin
                r_s2 <= '0;
                g_s2 <= '0;
                b_s2 <= '0;
            end
        end
    end

    assign vid.LCD_DE = de_s2;
    assign vid.LCD_R  = r_s2;
    assign vid.LCD_G  = g_s2;
    assign vid.LCD_B  = b_s2;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: a default-size instance and a small 48x48 STEP=5
// instance, both checked against a frame-level motion and pixel model.
module tb_sprite_renderer;

    logic PixelClk = 1'b0;
    logic nRST     = 1'b0;

    always #5 PixelClk = ~PixelClk;

    sprite_renderer_if vif_a ();
    sprite_renderer_if vif_b ();

    sprite_renderer #(.H_ACTIVE(480), .V_ACTIVE(272), .STEP(1)) dut (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .vid      (vif_a)
    );

    sprite_renderer #(.H_ACTIVE(48), .V_ACTIVE(48), .STEP(5)) dut_b (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .vid      (vif_b)
    );

    int checks   = 0;
    int failures = 0;

    int p_h [2] = '{480, 48};
    int p_v [2] = '{272, 48};
    int p_s [2] = '{1, 5};

    int m_spx [2];
    int m_spy [2];
    int m_dx  [2];
    int m_dy  [2];
    int m_idx [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_spx[k] = 0; m_spy[k] = 0; m_dx[k] = 0; m_dy[k] = 0; m_idx[k] = 0;
        end
    endtask

    // One frame of motion: move by STEP, clamp at the travel limits, reverse there.
    task automatic model_frame(input int k);
        bit bounced;
        int xl, yl;
        bounced = 0;
        xl = p_h[k] - 16;
        yl = p_v[k] - 16;
        if (m_dx[k] == 0) begin
            if (m_spx[k] + p_s[k] >= xl) begin m_spx[k] = xl; m_dx[k] = 1; bounced = 1; end
            else m_spx[k] = m_spx[k] + p_s[k];
        end else begin
            if (m_spx[k] <= p_s[k]) begin m_spx[k] = 0; m_dx[k] = 0; bounced = 1; end
            else m_spx[k] = m_spx[k] - p_s[k];
        end
        if (m_dy[k] == 0) begin
            if (m_spy[k] + p_s[k] >= yl) begin m_spy[k] = yl; m_dy[k] = 1; bounced = 1; end
            else m_spy[k] = m_spy[k] + p_s[k];
        end else begin
            if (m_spy[k] <= p_s[k]) begin m_spy[k] = 0; m_dy[k] = 0; bounced = 1; end
            else m_spy[k] = m_spy[k] - p_s[k];
        end
        if (bounced) m_idx[k] = (m_idx[k] + 1) % 8;
    endtask

    function automatic logic [15:0] model_colour(input int k);
`ifdef SPRITE_COLOR_CYCLE_EN
        int i;
        i = m_idx[k];
        if (i == 0) return {5'd31, 6'd63, 5'd31};
        return {((i % 2) != 0) ? 5'd31 : 5'd0,
                (((i / 2) % 2) != 0) ? 6'd63 : 6'd0,
                (((i / 4) % 2) != 0) ? 5'd31 : 5'd0};
`else
        if (k > 1) return 16'h0000;
        return {5'd0, 6'd63, 5'd0};
`endif
    endfunction

    // Concentric squares: a cell is lit when its distance to the nearest sprite edge is even.
    function automatic logic [15:0] model_pixel(input int k, input bit de, input int x, input int y);
        int rx, ry, d;
        if (!de) return 16'h0000;
        rx = (x - m_spx[k]) & 16'hFFFF;
        ry = (y - m_spy[k]) & 16'hFFFF;
        if (rx >= 16 || ry >= 16) return 16'h0000;
        d = rx;
        if (ry < d) d = ry;
        if (15 - rx < d) d = 15 - rx;
        if (15 - ry < d) d = 15 - ry;
        if ((d % 2) != 0) return 16'h0000;
        return model_colour(k);
    endfunction

    task automatic tick();
        @(posedge PixelClk);
        #1;
    endtask

    task automatic set_pix(input bit de, input int x, input int y);
        vif_a.de_in = de;
        vif_a.x_in  = 16'(x);
        vif_a.y_in  = 16'(y);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        set_pix(0, 0, 0);
        vif_a.frame_start = 1'b0;
        vif_b.frame_start = 1'b0;
        model_reset();
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic pulse_frames(input int n);
        vif_a.frame_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            model_frame(0);
        end
        vif_a.frame_start = 1'b0;
        tick();
    endtask

    // Drives n random pixels (biased around the sprite) and checks each output two cycles later.
    task automatic run_stream(input int n, input string name);
        logic [16:0] exp_q[$];
        logic [16:0] exp_v, got;
        int x, y;
        bit de;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                de = ($urandom_range(0, 3) != 0);
                x  = m_spx[0] + $urandom_range(0, 21) - 3;
                y  = m_spy[0] + $urandom_range(0, 21) - 3;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 479) x = 479;
                if (y > 271) y = 271;
                set_pix(de, x, y);
                exp_q.push_back({de, model_pixel(0, de, x, y)});
            end else begin
                set_pix(0, 0, 0);
            end
            tick();
            if (i >= 1) begin
                exp_v = exp_q.pop_front();
                got   = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL %s px%0d got=%h exp=%h (spx=%0d spy=%0d)", name, i - 1, got, exp_v, m_spx[0], m_spy[0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        set_pix(1, 0, 0);
        vif_a.frame_start = 1'b1;
        vif_b.frame_start = 1'b0;
        vif_b.de_in = 1'b0;
        vif_b.x_in  = '0;
        vif_b.y_in  = '0;
        model_reset();
        tick(); tick(); tick();
        checks++;
        if ({vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B} !== 17'h0) begin
            failures++; $display("FAIL reset_out got=%h exp=0", {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B});
        end
        checks++;
        if ({dut.spx, dut.spy} !== 32'h0) begin
            failures++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", dut.spx, dut.spy);
        end
        checks++;
        if ({dut.dir_x, dut.dir_y} !== 2'b00) begin
            failures++; $display("FAIL reset_dir got=%b exp=00", {dut.dir_x, dut.dir_y});
        end
        vif_a.frame_start = 1'b0;
        set_pix(0, 0, 0);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_rom_pattern();
        int tx [10] = '{0, 1, 2, 20, 15, 16, 0, 7, 6, 0};
        int ty [10] = '{0, 1, 2, 0, 3, 0, 15, 7, 7, 0};
        bit tl [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        bit td [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [16:0] exp_v, got;
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) set_pix(td[i], tx[i], ty[i]);
            else set_pix(0, 0, 0);
            tick();
            if (i >= 1) begin
                exp_v = {td[i-1], (td[i-1] && tl[i-1]) ? model_colour(0) : 16'h0000};
                got   = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL rom_xy(%0d,%0d) got=%h exp=%h", tx[i-1], ty[i-1], got, exp_v);
                end
            end
        end
    endtask

    task automatic test_bounce_x();
        do_reset();
        pulse_frames(464);
        checks++;
        if (dut.spx !== 16'd464 || dut.dir_x !== 1'b1) begin
            failures++; $display("FAIL bounce_x_clamp got=%0d/%b exp=464/1", dut.spx, dut.dir_x);
        end
        checks++;
        if (dut.spy !== 16'(m_spy[0]) || dut.dir_y !== 1'(m_dy[0])) begin
            failures++; $display("FAIL bounce_x_y got=%0d/%b exp=%0d/%0d", dut.spy, dut.dir_y, m_spy[0], m_dy[0]);
        end
        pulse_frames(1);
        checks++;
        if (dut.spx !== 16'd463 || dut.dir_x !== 1'b1) begin
            failures++; $display("FAIL bounce_x_back got=%0d/%b exp=463/1", dut.spx, dut.dir_x);
        end
        run_stream(40, "stream_after_bounce");
    endtask

    task automatic test_random_motion();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 400);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 1) == 0) pulse_frames($urandom_range(1, 3));
                else tick();
            end
            checks++;
            if (dut.spx !== 16'(m_spx[0]) || dut.spy !== 16'(m_spy[0]) ||
                {dut.dir_x, dut.dir_y} !== {1'(m_dx[0]), 1'(m_dy[0])}) begin
                failures++;
                $display("FAIL motion_r%0d got=%0d,%0d,%b%b exp=%0d,%0d,%0d%0d", r, dut.spx, dut.spy,
                         dut.dir_x, dut.dir_y, m_spx[0], m_spy[0], m_dx[0], m_dy[0]);
            end
            run_stream(30, "stream_random");
        end
    endtask

    task automatic test_corner();
        do_reset();
        for (int p = 1; p <= 14; p++) begin
            vif_b.frame_start = 1'b1;
            tick();
            model_frame(1);
            vif_b.frame_start = 1'b0;
            tick();
            checks++;
            if (dut_b.spx !== 16'(m_spx[1]) || dut_b.spy !== 16'(m_spy[1]) ||
                {dut_b.dir_x, dut_b.dir_y} !== {1'(m_dx[1]), 1'(m_dy[1])}) begin
                failures++;
                $display("FAIL corner_p%0d got=%0d,%0d,%b%b exp=%0d,%0d,%0d%0d", p, dut_b.spx, dut_b.spy,
                         dut_b.dir_x, dut_b.dir_y, m_spx[1], m_spy[1], m_dx[1], m_dy[1]);
            end
            if (p == 7) begin
                checks++;
                if (dut_b.spx !== 16'd32 || dut_b.spy !== 16'd32 || {dut_b.dir_x, dut_b.dir_y} !== 2'b11) begin
                    failures++;
                    $display("FAIL corner_clamp got=%0d,%0d,%b%b exp=32,32,11", dut_b.spx, dut_b.spy, dut_b.dir_x, dut_b.dir_y);
                end
`ifdef SPRITE_COLOR_CYCLE_EN
                checks++;
                if (dut_b.col_idx !== 3'd1) begin
                    failures++; $display("FAIL corner_idx got=%0d exp=1", dut_b.col_idx);
                end
`endif
            end
        end
    endtask

    task automatic test_fs_collision();
        logic [16:0] e0, e1, got;
        do_reset();
        pulse_frames(37);
        set_pix(1, m_spx[0], m_spy[0]);
        vif_a.frame_start = 1'b1;
        e0 = {1'b1, model_pixel(0, 1, m_spx[0], m_spy[0])};
        tick();
        model_frame(0);
        vif_a.frame_start = 1'b0;
        e1 = {1'b1, model_pixel(0, 1, m_spx[0] - 1, m_spy[0] - 1)};
        set_pix(1, m_spx[0] - 1, m_spy[0] - 1);
        tick();
        got = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
        checks++;
        if (got !== e0) begin
            failures++; $display("FAIL fs_collision_pre got=%h exp=%h", got, e0);
        end
        set_pix(0, 0, 0);
        tick();
        got = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
        checks++;
        if (got !== e1) begin
            failures++; $display("FAIL fs_collision_post got=%h exp=%h", got, e1);
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] exp_v, got;
        do_reset();
        set_pix(1, 0, 0);
        tick(); tick(); tick();
        checks++;
        if (vif_a.LCD_DE !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%b exp=1", vif_a.LCD_DE);
        end
        #2;
        nRST = 1'b0;
        #1;
        got = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
        checks++;
        if (got !== 17'h0) begin
            failures++; $display("FAIL areset_now got=%h exp=0", got);
        end
        model_reset();
        tick();
        nRST = 1'b1;
        tick();
        checks++;
        if (vif_a.LCD_DE !== 1'b0) begin
            failures++; $display("FAIL areset_lat1 got=%b exp=0", vif_a.LCD_DE);
        end
        tick();
        exp_v = {1'b1, model_pixel(0, 1, 0, 0)};
        got   = {vif_a.LCD_DE, vif_a.LCD_R, vif_a.LCD_G, vif_a.LCD_B};
        checks++;
        if (got !== exp_v) begin
            failures++; $display("FAIL areset_lat2 got=%h exp=%h", got, exp_v);
        end
        set_pix(0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_rom_pattern();
        test_bounce_x();
        test_random_motion();
        test_corner();
        test_fs_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter H_ACTIVE, default 480: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 272: active lines per frame.
REQ-003 Parameter STEP, default 1: sprite motion in pixels per frame per axis, range 1..15.
REQ-004 PixelClk  in  1: pixel clock, the only clock; all state updates on its rising edge.
REQ-005 nRST  in  1: reset, asynchronous assert, active-low.
REQ-006 de_in  in  1: active-pixel qualifier from the timing generator.
REQ-007 x_in  in  16: active-area column, 0..H_ACTIVE-1, valid when de_in=1.
REQ-008 y_in  in  16: active-area row, 0..V_ACTIVE-1, valid when de_in=1.
REQ-009 frame_start  in  1: one-cycle pulse, once per frame, during blanking.
REQ-010 LCD_DE  out  1: de_in delayed 2 cycles.
REQ-011 LCD_R / LCD_G / LCD_B  out  5 / 6 / 5: RGB565 pixel aligned with LCD_DE.

Function
REQ-012 Sprite SHALL be a 16x16 1-bit ROM of concentric squares: rows 0 and 15 all ones; row r, column c lit = ROM[r][15-c].
REQ-013 Position registers spx, spy (16 bit) SHALL hold the sprite's top-left corner, always within 0..H_ACTIVE-16 and 0..V_ACTIVE-16.
REQ-014 Direction flags dir_x (0=right, 1=left) and dir_y (0=down, 1=up) SHALL form a 4-state motion FSM: RD, RU, LD, LU.
REQ-015 Position and direction SHALL change only in the cycle after frame_start=1; otherwise they hold.
REQ-016 On update, moving right: if spx+STEP >= H_ACTIVE-16, spx := H_ACTIVE-16 and dir_x := 1; else spx := spx+STEP.
REQ-017 On update, moving left: if spx <= STEP, spx := 0 and dir_x := 0; else spx := spx-STEP.
REQ-018 Y axis SHALL follow REQ-016/017 with V_ACTIVE, spy, dir_y.
REQ-019 A corner hit (both axes clamp on one update) SHALL flip both flags in that update and count as a single bounce event.
REQ-020 Stage 1 SHALL register de_in, hit = (x_in-spx < 16) && (y_in-spy < 16) using unsigned 16-bit subtraction, row = y_in-spy [3:0], col = x_in-spx [3:0].
REQ-021 Stage 2 SHALL register LCD_DE = stage-1 de, and RGB = sprite colour when de && hit && ROM[row][15-col], else 0.
REQ-022 RGB SHALL be 0 whenever LCD_DE=0, regardless of x_in/y_in.
REQ-023 Pipeline latency de_in -> LCD_DE/RGB SHALL be exactly 2 PixelClk cycles, no bubbles, no backpressure.
REQ-024 If frame_start coincides with de_in=1 (protocol violation), that pixel SHALL use the pre-update position; no other effect.
REQ-025 frame_start held high N cycles SHALL cause N updates (edge detection not required).

Reset
REQ-026 nRST=0 SHALL asynchronously force spx=0, spy=0, state RD, both pipeline stages cleared, LCD_DE=0, LCD_R/G/B=0, colour index=0.
REQ-027 Reset mid-frame SHALL take effect immediately; first valid LCD_DE follows 2 cycles after first de_in=1 after release.

Configuration
REQ-028 Macro SPRITE_COLOR_CYCLE_EN defined: 3-bit colour index increments (mod 8) once per bounce event; colour = {R=idx[0]?31:0, G=idx[1]?63:0, B=idx[2]?31:0}, index 0 mapped to white (31/63/31).
REQ-029 Macro SPRITE_COLOR_CYCLE_EN undefined: colour fixed green (R=0, G=63, B=0); no index register present.

Verification
REQ-030 Reset, de_in=1, x_in=0, y_in=0 -> 2 cycles later LCD_DE=1, LCD_G=63, R=B=0 (default build).
REQ-031 spx=spy=0, x_in=1, y_in=1, de_in=1 -> RGB=0 (ROM[1][14]=0); x_in=2, y_in=2 -> G=63.
REQ-032 After reset, 464 frame_start pulses (STEP=1) -> spx=464, dir_x=1; next pulse -> spx=463.
REQ-033 STEP=5, spx=462 moving right, frame_start -> spx=464, dir_x=1 (clamp, no overshoot).
REQ-034 Drive to corner spx=464, spy=256 on the same update -> state LU; with SPRITE_COLOR_CYCLE_EN index increments by exactly 1.
REQ-035 de_in=1 with x_in=20 while spx=0 -> RGB=0; nRST pulsed mid-line -> LCD_DE and RGB 0 in the same cycle, asynchronously.
